// File: rtl/sad_search_ctrl_pkg.sv
// Shared definitions for the SAD block-match search controller:
// FSM state encoding, position-count helpers and the all-ones SAD seed.
package sad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Widest SAD supported; the top slices this down to its own SAD_W.
  localparam int          SAD_MAX_W = 64;
  localparam logic [63:0] SAD_MAX   = {64{1'b1}};

  // Window positions along the horizontal axis.
  function automatic int pos_cols(input int frame_w, input int win);
    return frame_w - win + 1;
  endfunction

  // Window positions along the vertical axis.
  function automatic int pos_rows(input int frame_h, input int win);
    return frame_h - win + 1;
  endfunction

endpackage

// File: rtl/sad_search_ctrl_if.sv
// Bus between the control unit / SAD datapath and the search controller.
// slave: the controller itself; master: whoever drives the search.
interface sad_search_ctrl_if #(parameter int SAD_W = 32);

  logic             Start;
  logic             Abort;
  logic             Stall;
  logic             IssueValid;
  logic [15:0]      IssueRow;
  logic [15:0]      IssueCol;
  logic             ResultValid;
  logic [SAD_W-1:0] ResultSAD;
  logic             Busy;
  logic             Done;
  logic             Aborted;
  logic [SAD_W-1:0] BestSAD;
  logic [15:0]      BestRow;
  logic [15:0]      BestCol;

  modport slave (
    input  Start, Abort, Stall, ResultValid, ResultSAD,
    output IssueValid, IssueRow, IssueCol, Busy, Done, Aborted,
           BestSAD, BestRow, BestCol
  );

  modport master (
    output Start, Abort, Stall, ResultValid, ResultSAD,
    input  IssueValid, IssueRow, IssueCol, Busy, Done, Aborted,
           BestSAD, BestRow, BestCol
  );

endinterface

// File: rtl/sad_search_ctrl_pos_counter.sv
// Raster position counter (column fastest). Advances on en, returns to
// (0,0) on clr or after the last position; last flags the final position.
module sad_pos_counter #(
  parameter int COLS = 61,
  parameter int ROWS = 61
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] row,
  output logic [15:0] col,
  output logic        last
);

  logic [15:0] row_r;
  logic [15:0] col_r;
  logic        col_end_s;

  assign col_end_s = (col_r == 16'(COLS - 1));
  assign last      = col_end_s && (row_r == 16'(ROWS - 1));
  assign row       = row_r;
  assign col       = col_r;

  // Position register: clear, hold, or step to the next raster position.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      row_r <= 16'd0;
      col_r <= 16'd0;
    end else if (clr) begin
      row_r <= 16'd0;
      col_r <= 16'd0;
    end else if (en) begin
      if (last) begin
        row_r <= 16'd0;
        col_r <= 16'd0;
      end else if (col_end_s) begin
        row_r <= row_r + 16'd1;
        col_r <= 16'd0;
      end else begin
        col_r <= col_r + 16'd1;
      end
    end
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// SAD block-match search controller. Issues one window position per cycle
// into the SAD pipeline, tags in-order results with their positions and
// keeps the running minimum. Optional feature macro: SAD_EARLY_EXIT_EN
// (a zero SAD accepted while issuing ends the issue phase early).
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int WIN     = 4,
  parameter int MAX_OUT = 4,
  parameter int SAD_W   = 32
) (
  input logic             Clk,
  input logic             Reset,
  sad_search_ctrl_if.slave bus
);

  localparam int COLS = pos_cols(FRAME_W, WIN);
  localparam int ROWS = pos_rows(FRAME_H, WIN);
  localparam int OW   = $clog2(MAX_OUT + 1);
  localparam logic [SAD_W-1:0] SAD_SEED = SAD_MAX[SAD_W-1:0];

  state_t           state_r;
  state_t           state_s;
  logic [OW-1:0]    outst_r;
  logic             start_s;
  logic             abort_act_s;
  logic             issue_fire_s;
  logic             res_acc_s;
  logic             early_s;
  logic [15:0]      iss_row_s;
  logic [15:0]      iss_col_s;
  logic             iss_last_s;
  logic [15:0]      ret_row_s;
  logic [15:0]      ret_col_s;
  logic             ret_last_s;
  logic             unused_ret_last_s;
  logic             abort_seen_r;
  logic             busy_r;
  logic             done_r;
  logic             aborted_r;
  logic [SAD_W-1:0] best_sad_r;
  logic [15:0]      best_row_r;
  logic [15:0]      best_col_r;

  assign start_s      = (state_r == ST_IDLE) && bus.Start;
  assign abort_act_s  = bus.Abort && ((state_r == ST_ISSUE) || (state_r == ST_DRAIN));
  assign issue_fire_s = (state_r == ST_ISSUE) && !bus.Stall && !bus.Abort &&
                        (outst_r < OW'(MAX_OUT));
  // Results arriving with nothing outstanding are stray and dropped.
  assign res_acc_s    = bus.ResultValid && (outst_r != '0);
  // The return side only needs its position; end of scan is known from outst.
  assign unused_ret_last_s = ret_last_s;

`ifdef SAD_EARLY_EXIT_EN
  assign early_s = (state_r == ST_ISSUE) && res_acc_s && (bus.ResultSAD == '0);
`else
  assign early_s = 1'b0;
`endif

  sad_pos_counter #(.COLS(COLS), .ROWS(ROWS)) u_issue_pos (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (start_s),
    .en    (issue_fire_s),
    .row   (iss_row_s),
    .col   (iss_col_s),
    .last  (iss_last_s)
  );

  sad_pos_counter #(.COLS(COLS), .ROWS(ROWS)) u_return_pos (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (start_s),
    .en    (res_acc_s),
    .row   (ret_row_s),
    .col   (ret_col_s),
    .last  (ret_last_s)
  );

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.Start) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.Abort || (issue_fire_s && iss_last_s) || early_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (outst_r == '0) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Outstanding count: +1 per issue, -1 per accepted result, both cancel.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      outst_r <= '0;
    end else begin
      case ({issue_fire_s, res_acc_s})
        2'b10:   outst_r <= outst_r + OW'(1);
        2'b01:   outst_r <= outst_r - OW'(1);
        default: outst_r <= outst_r;
      endcase
    end
  end

  // Status outputs, registered from the next state so they track the FSM.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_s == ST_DONE);
    end
  end

  // Abort bookkeeping: remember an abort during the search, publish it at DONE.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      abort_seen_r <= 1'b0;
      aborted_r    <= 1'b0;
    end else if (start_s) begin
      abort_seen_r <= 1'b0;
      aborted_r    <= 1'b0;
    end else begin
      if (abort_act_s) begin
        abort_seen_r <= 1'b1;
      end
      if ((state_s == ST_DONE) && (state_r != ST_DONE)) begin
        aborted_r <= abort_seen_r || abort_act_s;
      end
    end
  end

  // Running minimum; strict compare so ties keep the earlier position.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      best_sad_r <= SAD_SEED;
      best_row_r <= 16'd0;
      best_col_r <= 16'd0;
    end else if (start_s) begin
      best_sad_r <= SAD_SEED;
      best_row_r <= 16'd0;
      best_col_r <= 16'd0;
    end else if (res_acc_s && (bus.ResultSAD < best_sad_r)) begin
      best_sad_r <= bus.ResultSAD;
      best_row_r <= ret_row_s;
      best_col_r <= ret_col_s;
    end
  end

  assign bus.IssueValid = issue_fire_s;
  assign bus.IssueRow   = iss_row_s;
  assign bus.IssueCol   = iss_col_s;
  assign bus.Busy       = busy_r;
  assign bus.Done       = done_r;
  assign bus.Aborted    = aborted_r;
  assign bus.BestSAD    = best_sad_r;
  assign bus.BestRow    = best_row_r;
  assign bus.BestCol    = best_col_r;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Self-checking bench for sad_search_ctrl on an 8x8 frame with a 4x4 window
// (5x5 = 25 positions). A behavioural responder returns results in order
// after a fixed latency; expectations come from the scan rules.
module tb_sad_search_ctrl;

  localparam int NCOL    = 5;
  localparam int NPOS    = 25;
  localparam int MAX_OUT = 4;

  logic Clk;
  logic Reset;
  int   total;
  int   bad;
  int unsigned sad_of [NPOS];

  sad_search_ctrl_if #(.SAD_W(32)) bus ();

  sad_search_ctrl #(
    .FRAME_W (8),
    .FRAME_H (8),
    .WIN     (4),
    .MAX_OUT (MAX_OUT),
    .SAD_W   (32)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"},   64'(bus.IssueValid), 64'd0);
    chk({tag, "_irow"},    64'(bus.IssueRow),   64'd0);
    chk({tag, "_icol"},    64'(bus.IssueCol),   64'd0);
    chk({tag, "_busy"},    64'(bus.Busy),       64'd0);
    chk({tag, "_done"},    64'(bus.Done),       64'd0);
    chk({tag, "_aborted"}, 64'(bus.Aborted),    64'd0);
    chk({tag, "_bestsad"}, 64'(bus.BestSAD),    64'hFFFF_FFFF);
    chk({tag, "_bestrow"}, 64'(bus.BestRow),    64'd0);
    chk({tag, "_bestcol"}, 64'(bus.BestCol),    64'd0);
  endtask

  // One complete search. The model tracks what the controller may issue,
  // how many positions are in flight and the expected minimum.
  task automatic run_search(input string name, input int lat, input int abort_at,
                            input int st_lo, input int st_hi, input bit rnd_stall,
                            input bit mid_start, input bit rst_drain, input int exp_issues);
    int  issued, returned, outm, bi;
    int  due_q [$];
    bit  issuing, done_seen, rv, iv, exp_iv;
    int unsigned bsad;
    issued = 0; returned = 0; outm = 0;
    issuing = 1'b1; done_seen = 1'b0;
    @(negedge Clk);
    bus.Start = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge Clk);
      bus.Start = (mid_start && c == 8);
      bus.Stall = (c >= st_lo && c <= st_hi) || (rnd_stall && $urandom_range(3) == 0);
      bus.Abort = (abort_at >= 0) && issuing && (issued == abort_at);
      rv = (due_q.size() > 0) && (due_q[0] <= c);
      bus.ResultValid = rv;
      bus.ResultSAD   = rv ? sad_of[returned] : $urandom;
      #1;
      if (bus.Done) begin
        done_seen = 1'b1;
        bsad = 32'hFFFF_FFFF; bi = 0;
        for (int i = 0; i < issued; i++) begin
          if (sad_of[i] < bsad) begin
            bsad = sad_of[i];
            bi   = i;
          end
        end
        chk({name, "_issues"},   64'(issued),      64'(exp_issues));
        chk({name, "_returned"}, 64'(returned),    64'(issued));
        chk({name, "_aborted"},  64'(bus.Aborted), 64'(abort_at >= 0));
        chk({name, "_bestsad"},  64'(bus.BestSAD), 64'(bsad));
        chk({name, "_bestrow"},  64'(bus.BestRow), 64'(bi / NCOL));
        chk({name, "_bestcol"},  64'(bus.BestCol), 64'(bi % NCOL));
        bus.ResultValid = 1'b0;
        bus.Abort = 1'b0;
        bus.Stall = 1'b0;
        @(negedge Clk);
        #1;
        chk({name, "_done_pulse"}, 64'(bus.Done),    64'd0);
        chk({name, "_idle_busy"},  64'(bus.Busy),    64'd0);
        chk({name, "_held_sad"},   64'(bus.BestSAD), 64'(bsad));
        break;
      end
      chk({name, "_busy"}, 64'(bus.Busy), 64'd1);
      exp_iv = issuing && !bus.Stall && !bus.Abort && (outm < MAX_OUT);
      iv = bus.IssueValid;
      chk({name, "_issue_valid"}, 64'(iv), 64'(exp_iv));
      if (iv) begin
        chk({name, "_issue_row"}, 64'(bus.IssueRow), 64'(issued / NCOL));
        chk({name, "_issue_col"}, 64'(bus.IssueCol), 64'(issued % NCOL));
        due_q.push_back(c + lat);
        issued++;
      end
      if (bus.Abort) issuing = 1'b0;
      if (issued == NPOS) issuing = 1'b0;
      if (rv) begin
`ifdef SAD_EARLY_EXIT_EN
        if (issuing && sad_of[returned] == 0) issuing = 1'b0;
`endif
        void'(due_q.pop_front());
        returned++;
      end
      outm = outm + (iv ? 1 : 0) - (rv ? 1 : 0);
      chk({name, "_outstanding_bound"}, 64'(outm <= MAX_OUT), 64'd1);
      if (rst_drain && !issuing && outm > 0) begin
        Reset = 1'b0;
        #1;
        chk_reset_values({name, "_rst"});
        bus.ResultValid = 1'b0;
        bus.Stall = 1'b0;
        bus.Abort = 1'b0;
        bus.Start = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        #1;
        chk_reset_values({name, "_post"});
        return;
      end
    end
    if (!done_seen) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b0;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    bus.Stall = 1'b0;
    bus.ResultValid = 1'b0;
    bus.ResultSAD = 32'd0;
    #12;
    chk_reset_values("reset");
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    #1;
    chk_reset_values("after_reset");

    // Descending SADs: minimum at the last position.
    for (int i = 0; i < NPOS; i++) sad_of[i] = 100 - i;
    run_search("descend", 3, -1, -1, -1, 1'b0, 1'b0, 1'b0, NPOS);

    // All ties: the first position must win.
    for (int i = 0; i < NPOS; i++) sad_of[i] = 50;
    run_search("ties", 3, -1, -1, -1, 1'b0, 1'b0, 1'b0, NPOS);

    // Stray result and Abort while idle change nothing.
    @(negedge Clk);
    bus.ResultValid = 1'b1;
    bus.ResultSAD   = 32'd0;
    bus.Abort       = 1'b1;
    @(negedge Clk);
    bus.ResultValid = 1'b0;
    bus.Abort       = 1'b0;
    #1;
    chk("idle_stray_sad",  64'(bus.BestSAD), 64'd50);
    chk("idle_abort_flag", 64'(bus.Aborted), 64'd0);
    chk("idle_busy",       64'(bus.Busy),    64'd0);

    // Stall window cycles 3..7.
    for (int i = 0; i < NPOS; i++) sad_of[i] = 100 - i;
    run_search("stall", 3, -1, 3, 7, 1'b0, 1'b0, 1'b0, NPOS);

    // Long return latency saturates the outstanding limit.
    for (int i = 0; i < NPOS; i++) sad_of[i] = $urandom_range(1000, 1);
    run_search("latency10", 10, -1, -1, -1, 1'b0, 1'b0, 1'b0, NPOS);

    // Abort after six issues.
    for (int i = 0; i < NPOS; i++) sad_of[i] = $urandom_range(1000, 1);
    run_search("abort", 3, 6, -1, -1, 1'b0, 1'b0, 1'b0, 6);

    // Zero SAD at index 2.
    for (int i = 0; i < NPOS; i++) sad_of[i] = 100 - i;
    sad_of[2] = 0;
`ifdef SAD_EARLY_EXIT_EN
    run_search("zero", 3, -1, -1, -1, 1'b0, 1'b0, 1'b0, 6);
`else
    run_search("zero", 3, -1, -1, -1, 1'b0, 1'b0, 1'b0, NPOS);
`endif

    // Random stalls, random latency, Start pulsed mid-search.
    for (int i = 0; i < NPOS; i++) sad_of[i] = $urandom_range(1000, 1);
    run_search("random", int'($urandom_range(8, 1)), -1, -1, -1, 1'b1, 1'b1, 1'b0, NPOS);

    // Reset while draining.
    for (int i = 0; i < NPOS; i++) sad_of[i] = $urandom_range(1000, 1);
    run_search("rst_drain", 10, -1, -1, -1, 1'b0, 1'b0, 1'b1, NPOS);

    // A fresh search after the mid-drain reset still works.
    for (int i = 0; i < NPOS; i++) sad_of[i] = 100 - i;
    run_search("after_rst", 2, -1, -1, -1, 1'b0, 1'b0, 1'b0, NPOS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
